// File: rtl/store_forward_buffer.sv
// rtl/store_forward_buffer.sv - in-order store buffer with commit, drain and load forwarding
module store_forward_buffer #(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_store_valid,
    input  logic [31:0]                  in_store_addr,
    input  logic [31:0]                  in_store_data,
    input  logic [2:0]                   in_store_funct3,
    input  logic [ROB_IDX_W-1:0]         in_store_rob_idx,
    input  logic                         in_commit_valid,
    input  logic [ROB_IDX_W-1:0]         in_commit_rob_idx,
    input  logic                         in_flush,
    input  logic                         in_load_valid,
    input  logic [31:0]                  in_load_addr,
    input  logic [2:0]                   in_load_funct3,
    output logic                         out_fwd_hit,
    output logic [31:0]                  out_fwd_data,
    output logic                         out_fwd_stall,
    output logic                         out_drain_valid,
    output logic [31:0]                  out_drain_addr,
    output logic [31:0]                  out_drain_data,
    output logic [2:0]                   out_drain_funct3,
    input  logic                         in_drain_ready,
    output logic                         out_full,
    output logic                         out_empty,
    output logic [$clog2(DEPTH+1)-1:0]   out_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int PW1   = PTR_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W:0]          head, tail, head_next, surv;
    logic [PTR_W-1:0]        head_idx, tail_idx;
    logic [DEPTH-1:0]        ent_valid, ent_committed, commit_next;
    logic [31:0]             ent_addr   [DEPTH];
    logic [31:0]             ent_data   [DEPTH];
    logic [31:0]             ent_lane   [DEPTH];
    logic [3:0]              ent_mask   [DEPTH];
    logic [2:0]              ent_funct3 [DEPTH];
    logic [ROB_IDX_W-1:0]    ent_rob    [DEPTH];
    logic                    pop, alloc;

    function automatic logic [3:0] byte_mask(input logic [1:0] offset, input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001 << offset;
            2'b01:   return offset[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] data, input logic [1:0] offset,
                                              input logic [1:0] size);
        case (size)
            2'b00:   return data << {offset, 3'b000};
            2'b01:   return data << {offset[1], 4'b0000};
            default: return data;
        endcase
    endfunction

    assign head_idx        = head[PTR_W-1:0];
    assign tail_idx        = tail[PTR_W-1:0];
    assign out_full        = (head[PTR_W] != tail[PTR_W]) && (head_idx == tail_idx);
    assign out_empty       = (head == tail);
    assign out_count       = CNT_W'(tail - head);
    assign out_drain_valid = ent_valid[head_idx] && ent_committed[head_idx];
    assign out_drain_addr   = out_drain_valid ? ent_addr[head_idx]   : 32'd0;
    assign out_drain_data   = out_drain_valid ? ent_data[head_idx]   : 32'd0;
    assign out_drain_funct3 = out_drain_valid ? ent_funct3[head_idx] : 3'd0;

    assign pop       = out_drain_valid && in_drain_ready;
    assign alloc     = in_store_valid && !out_full && !in_flush;
    assign head_next = head + PW1'(pop);

    // A same-cycle commit is applied before the flush decides which entries survive.
    always_comb begin
        commit_next = ent_committed;
        surv        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (in_commit_valid && ent_valid[i] && ent_rob[i] == in_commit_rob_idx)
                commit_next[i] = 1'b1;
            surv = surv + PW1'(ent_valid[i] & commit_next[i]);
        end
        surv = surv - PW1'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            ent_valid     <= '0;
            ent_committed <= '0;
        end else begin
            ent_committed <= commit_next;
            head          <= head_next;
            if (in_flush) begin
                for (int i = 0; i < DEPTH; i++)
                    if (!commit_next[i])
                        ent_valid[i] <= 1'b0;
                tail <= head_next + surv;
            end
            if (pop) begin
                ent_valid[head_idx]     <= 1'b0;
                ent_committed[head_idx] <= 1'b0;
            end
            if (alloc) begin
                ent_valid[tail_idx]     <= 1'b1;
                ent_committed[tail_idx] <= 1'b0;
                ent_addr[tail_idx]      <= in_store_addr;
                ent_data[tail_idx]      <= in_store_data;
                ent_funct3[tail_idx]    <= in_store_funct3;
                ent_rob[tail_idx]       <= in_store_rob_idx;
                ent_mask[tail_idx]      <= byte_mask(in_store_addr[1:0], in_store_funct3[1:0]);
                ent_lane[tail_idx]      <= lane_data(in_store_data, in_store_addr[1:0],
                                                     in_store_funct3[1:0]);
                tail                    <= tail + 1'b1;
            end
        end
    end

    logic [3:0]       ld_mask, sel_mask;
    logic [31:0]      sel_lane, shifted, ext;
    logic [1:0]       ld_shift;
    logic [PTR_W-1:0] idx;
    logic             found, covers;

    // Walk from head toward tail so the youngest overlapping entry wins.
    always_comb begin
        ld_mask  = byte_mask(in_load_addr[1:0], in_load_funct3[1:0]);
        found    = 1'b0;
        sel_mask = '0;
        sel_lane = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_idx + PTR_W'(i);
            if (ent_valid[idx] && ent_addr[idx][31:2] == in_load_addr[31:2]
                && |(ent_mask[idx] & ld_mask)) begin
                found    = 1'b1;
                sel_mask = ent_mask[idx];
                sel_lane = ent_lane[idx];
            end
        end
        covers = ((sel_mask & ld_mask) == ld_mask);
        case (in_load_funct3[1:0])
            2'b00:   ld_shift = in_load_addr[1:0];
            2'b01:   ld_shift = {in_load_addr[1], 1'b0};
            default: ld_shift = 2'b00;
        endcase
        shifted = sel_lane >> {ld_shift, 3'b000};
        case (in_load_funct3[1:0])
            2'b00:   ext = in_load_funct3[2] ? {24'd0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ext = in_load_funct3[2] ? {16'd0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
        out_fwd_hit   = in_load_valid && found && covers;
        out_fwd_stall = in_load_valid && found && !covers;
        out_fwd_data  = out_fwd_hit ? ext : 32'd0;
    end
endmodule

// File: tb/tb_store_forward_buffer.sv
// tb/tb_store_forward_buffer.sv - directed plus randomized check against a queue model
module tb_store_forward_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        in_reset;
    logic        in_store_valid;
    logic [31:0] in_store_addr, in_store_data;
    logic [2:0]  in_store_funct3;
    logic [3:0]  in_store_rob_idx;
    logic        in_commit_valid;
    logic [3:0]  in_commit_rob_idx;
    logic        in_flush;
    logic        in_load_valid;
    logic [31:0] in_load_addr;
    logic [2:0]  in_load_funct3;
    logic        out_fwd_hit, out_fwd_stall, out_drain_valid, in_drain_ready;
    logic [31:0] out_fwd_data, out_drain_addr, out_drain_data;
    logic [2:0]  out_drain_funct3;
    logic        out_full, out_empty;
    logic [2:0]  out_count;

    store_forward_buffer #(.DEPTH(DEPTH), .ROB_IDX_W(4)) dut (
        .clk(clk), .reset(in_reset),
        .in_store_valid(in_store_valid), .in_store_addr(in_store_addr),
        .in_store_data(in_store_data), .in_store_funct3(in_store_funct3),
        .in_store_rob_idx(in_store_rob_idx),
        .in_commit_valid(in_commit_valid), .in_commit_rob_idx(in_commit_rob_idx),
        .in_flush(in_flush),
        .in_load_valid(in_load_valid), .in_load_addr(in_load_addr),
        .in_load_funct3(in_load_funct3),
        .out_fwd_hit(out_fwd_hit), .out_fwd_data(out_fwd_data), .out_fwd_stall(out_fwd_stall),
        .out_drain_valid(out_drain_valid), .out_drain_addr(out_drain_addr),
        .out_drain_data(out_drain_data), .out_drain_funct3(out_drain_funct3),
        .in_drain_ready(in_drain_ready),
        .out_full(out_full), .out_empty(out_empty), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic [3:0]  rob;
        bit          committed;
    } ent_t;

    ent_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] next_rob = 4'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Byte-address view: youngest overlapping store decides hit, stall or miss.
    task automatic model_fwd(output bit hit, output bit stall, output logic [31:0] data);
        int          lsz, ssz, ov;
        logic [31:0] lbase, sbase, b;
        hit = 0; stall = 0; data = 32'd0;
        if (!in_load_valid) return;
        lsz   = acc_size(in_load_funct3);
        lbase = in_load_addr & ~(lsz - 1);
        for (int e = q.size() - 1; e >= 0; e--) begin
            ssz   = acc_size(q[e].f3);
            sbase = q[e].addr & ~(ssz - 1);
            ov    = 0;
            for (int k = 0; k < lsz; k++) begin
                b = lbase + k;
                if (b >= sbase && b < sbase + ssz) ov++;
            end
            if (ov == 0) continue;
            if (ov < lsz) begin
                stall = 1;
                return;
            end
            hit = 1;
            for (int k = 0; k < lsz; k++)
                data[8*k +: 8] = q[e].data[8*int'(lbase + k - sbase) +: 8];
            if (!in_load_funct3[2] && lsz < 4 && data[8*lsz-1])
                data = data | ~((32'h1 << (8*lsz)) - 1);
            return;
        end
    endtask

    task automatic compare_all();
        bit          eh, es, edv;
        logic [31:0] ed;
        model_fwd(eh, es, ed);
        edv = (q.size() > 0) && q[0].committed;
        check("count", 32'(out_count), q.size());
        check("full", 32'(out_full), 32'(q.size() == DEPTH));
        check("empty", 32'(out_empty), 32'(q.size() == 0));
        check("drain_valid", 32'(out_drain_valid), 32'(edv));
        if (edv) begin
            check("drain_addr", out_drain_addr, q[0].addr);
            check("drain_data", out_drain_data, q[0].data);
            check("drain_funct3", 32'(out_drain_funct3), 32'(q[0].f3));
        end
        check("fwd_hit", 32'(out_fwd_hit), 32'(eh));
        check("fwd_stall", 32'(out_fwd_stall), 32'(es));
        if (eh || !in_load_valid) check("fwd_data", out_fwd_data, ed);
    endtask

    task automatic model_update();
        bit   pop, was_full;
        ent_t keep[$];
        ent_t n;
        if (in_reset) begin
            q.delete();
            return;
        end
        pop      = (q.size() > 0) && q[0].committed && in_drain_ready;
        was_full = (q.size() == DEPTH);
        if (in_commit_valid)
            foreach (q[i]) if (q[i].rob == in_commit_rob_idx) q[i].committed = 1;
        if (pop) void'(q.pop_front());
        if (in_flush) begin
            foreach (q[i]) if (q[i].committed) keep.push_back(q[i]);
            q = keep;
        end
        if (in_store_valid && !was_full && !in_flush) begin
            n.addr = in_store_addr; n.data = in_store_data; n.f3 = in_store_funct3;
            n.rob = in_store_rob_idx; n.committed = 0;
            q.push_back(n);
            next_rob = next_rob + 4'd1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_reset = 0; in_store_valid = 0; in_store_addr = 0; in_store_data = 0;
        in_store_funct3 = 0; in_store_rob_idx = 0; in_commit_valid = 0; in_commit_rob_idx = 0;
        in_flush = 0; in_load_valid = 0; in_load_addr = 0; in_load_funct3 = 0;
        in_drain_ready = 0;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                              input logic [3:0] rob);
        in_store_valid = 1; in_store_addr = a; in_store_data = d;
        in_store_funct3 = f3; in_store_rob_idx = rob;
        step();
        in_store_valid = 0;
    endtask

    task automatic probe(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic eh, input logic es, input logic [31:0] ed);
        in_load_valid = 1; in_load_addr = a; in_load_funct3 = f3;
        #2;
        check({tag, "_hit"}, 32'(out_fwd_hit), 32'(eh));
        check({tag, "_stall"}, 32'(out_fwd_stall), 32'(es));
        if (eh) check({tag, "_data"}, out_fwd_data, ed);
        step();
        in_load_valid = 0;
    endtask

    task automatic do_reset();
        in_reset = 1;
        step();
        in_reset = 0;
    endtask

    logic [2:0] ld_f3s [5];
    int         r, sz;

    initial begin
        ld_f3s[0] = 3'd0; ld_f3s[1] = 3'd1; ld_f3s[2] = 3'd2; ld_f3s[3] = 3'd4; ld_f3s[4] = 3'd5;
        clear_inputs();
        in_reset = 1;
        @(posedge clk);
        #1;
        #2;
        check("rst_empty", 32'(out_empty), 32'd1);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_drain_addr", out_drain_addr, 32'd0);
        step();
        in_reset = 0;

        push_store(32'h100, 32'hDEADBEEF, 3'b010, 4'd3);
        #2;
        check("t1_count", 32'(out_count), 32'd1);
        check("t1_drain_valid", 32'(out_drain_valid), 32'd0);
        probe("t1_lw", 32'h100, 3'b010, 1'b1, 1'b0, 32'hDEADBEEF);

        in_commit_valid = 1; in_commit_rob_idx = 4'd3;
        step();
        in_commit_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("t2_dvalid", 32'(out_drain_valid), 32'd1);
            check("t2_daddr", out_drain_addr, 32'h100);
            check("t2_dfunct3", 32'(out_drain_funct3), 32'd2);
            step();
        end
        in_drain_ready = 1;
        step();
        in_drain_ready = 0;
        #2;
        check("t2_empty", 32'(out_empty), 32'd1);
        step();

        push_store(32'h203, 32'h80, 3'b000, 4'd5);
        probe("t3_lb", 32'h203, 3'b000, 1'b1, 1'b0, 32'hFFFFFF80);
        probe("t3_lbu", 32'h203, 3'b100, 1'b1, 1'b0, 32'h00000080);
        probe("t3_lw", 32'h200, 3'b010, 1'b0, 1'b1, 32'd0);
        probe("t3_miss", 32'h202, 3'b000, 1'b0, 1'b0, 32'd0);
        do_reset();

        push_store(32'h300, 32'h11111111, 3'b010, 4'd1);
        push_store(32'h300, 32'h22, 3'b000, 4'd2);
        probe("t4_lb", 32'h300, 3'b000, 1'b1, 1'b0, 32'h22);
        probe("t4_lh", 32'h300, 3'b001, 1'b0, 1'b1, 32'd0);
        do_reset();

        for (int i = 0; i < 4; i++) push_store(32'h400 + 4*i, $urandom, 3'b010, 4'(i));
        #2;
        check("t5_full", 32'(out_full), 32'd1);
        push_store(32'h410, 32'h5, 3'b010, 4'd4);
        #2;
        check("t5_count_full", 32'(out_count), 32'd4);
        in_commit_valid = 1; in_commit_rob_idx = 4'd0;
        step();
        in_commit_rob_idx = 4'd1;
        step();
        in_commit_valid = 0; in_flush = 1;
        step();
        in_flush = 0;
        #2;
        check("t5_count_flush", 32'(out_count), 32'd2);
        in_drain_ready = 1;
        #1;
        check("t5_drain0", out_drain_addr, 32'h400);
        step();
        #2;
        check("t5_drain1", out_drain_addr, 32'h404);
        step();
        in_drain_ready = 0;
        #2;
        check("t5_empty", 32'(out_empty), 32'd1);
        push_store(32'h420, 32'h7, 3'b010, 4'd9);
        #2;
        check("t5_realloc", 32'(out_count), 32'd1);
        do_reset();

        push_store(32'h500, 32'hCAFEF00D, 3'b010, 4'd7);
        in_commit_valid = 1; in_commit_rob_idx = 4'd7; in_flush = 1;
        step();
        in_commit_valid = 0; in_flush = 0;
        #2;
        check("t6_survive", 32'(out_drain_valid), 32'd1);
        step();
        do_reset();
        #2;
        check("t6_rst_empty", 32'(out_empty), 32'd1);
        check("t6_rst_dvalid", 32'(out_drain_valid), 32'd0);

        next_rob = 4'd0;
        for (int c = 0; c < 3000; c++) begin
            clear_inputs();
            in_reset         = ($urandom_range(0, 199) == 0);
            in_store_valid   = $urandom_range(0, 1);
            in_store_funct3  = 3'($urandom_range(0, 2));
            sz               = acc_size(in_store_funct3);
            in_store_addr    = (32'h600 + $urandom_range(0, 15)) & ~(sz - 1);
            in_store_data    = $urandom;
            in_store_rob_idx = next_rob;
            r = $urandom_range(0, 99);
            if (r < 35) begin
                foreach (q[i]) if (!q[i].committed && !in_commit_valid) begin
                    in_commit_valid = 1; in_commit_rob_idx = q[i].rob;
                end
            end else if (r < 40) begin
                in_commit_valid = 1; in_commit_rob_idx = next_rob + 4'd8;
            end
            in_flush       = ($urandom_range(0, 19) == 0);
            in_load_valid  = ($urandom_range(0, 9) < 7);
            in_load_funct3 = ld_f3s[$urandom_range(0, 4)];
            sz             = acc_size(in_load_funct3);
            in_load_addr   = (32'h600 + $urandom_range(0, 15)) & ~(sz - 1);
            in_drain_ready = $urandom_range(0, 1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/store_forward_buffer.md
# store_forward_buffer

Parametrised in-order store buffer for the data-memory stage. It sits between the execute/memory pipeline and the data cache. It:
- holds speculative stores tagged with their ROB index;
- marks them committed when the ROB retires them;
- drains committed stores to the cache in program order through a valid/ready port;
- forwards store data to younger loads, or requests a stall when it cannot forward.

Uncommitted entries are discarded on a pipeline flush.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥2
- `ROB_IDX_W`, 4, width of ROB index tags
- `clk` in 1, clock
- `reset` in 1, reset; synchronous, active-high
- `in_store_valid` in 1, allocate a store this cycle
- `in_store_addr` in 32, byte address
- `in_store_data` in 32, raw rs2 value
- `in_store_funct3` in 3, 000 SB / 001 SH / 010 SW
- `in_store_rob_idx` in ROB_IDX_W, ROB tag of the store
- `in_commit_valid` in 1, ROB retires a store
- `in_commit_rob_idx` in ROB_IDX_W, tag being retired
- `in_flush` in 1, discard all uncommitted entries
- `in_load_valid` in 1, a load is being looked up
- `in_load_addr` in 32, load byte address
- `in_load_funct3` in 3, LB/LH/LW/LBU/LHU
- `out_fwd_hit` out 1, load fully satisfied from the buffer
- `out_fwd_data` out 32, forwarded, extended load result
- `out_fwd_stall` out 1, partial overlap; the load must wait
- `out_drain_valid` out 1, head entry offered to the cache
- `out_drain_addr` out 32, head address
- `out_drain_data` out 32, head raw data
- `out_drain_funct3` out 3, head funct3
- `in_drain_ready` in 1, cache accepts the head
- `out_full` out 1, no free entry
- `out_empty` out 1, no valid entry
- `out_count` out $clog2(DEPTH+1), number of valid entries

## Operation
- **Entry contents:**
  - valid, committed, addr, raw data, funct3, rob_idx.
  - 4-bit byte mask: SB gives 1<<addr[1:0]; SH gives 0011<<(addr[1]*2); SW gives 1111.
  - Lane data: data shifted into the same byte lanes.
  - For SH, addr[0] is ignored; for SW, addr[1:0] are ignored. Misaligned accesses are unsupported.
- **Pointers:** circular head and tail, each $clog2(DEPTH) bits plus one wrap bit.
  - full = pointers equal with wrap bits differing.
  - empty = pointers fully equal.
- **Allocate:**
  - Requires `in_store_valid && !out_full && !in_flush`; the entry is written at tail and tail advances.
  - An allocate request while full is dropped. The producer must stall on `out_full`.
- **Commit:**
  - The valid entry whose rob_idx equals `in_commit_rob_idx` sets its committed bit.
  - A commit that matches no entry has no effect.
  - Invariant: committed entries are contiguous from head.
- **Flush:**
  - Clears every entry that is not committed, including an entry committed in the same cycle? No: a same-cycle commit takes effect first, so that entry survives.
  - tail = head + number of surviving committed entries.
  - A same-cycle allocate is dropped. A same-cycle pop still happens.
- **Drain:**
  - `out_drain_valid` = head valid && head committed; the payload is the head entry.
  - When `in_drain_ready && out_drain_valid`, the head is cleared and head advances.
- **Simultaneous allocate and pop:** both occur, and count is unchanged.
  - `out_full` is computed from registered state, so an allocate while full is refused even if a pop happens in the same cycle.
- **Forwarding (combinational, valid only when `in_load_valid`; otherwise hit=stall=0, data=0):**
  - Load mask is computed as for stores.
  - Candidates are valid entries with addr[31:2] == load addr[31:2] and (entry mask & load mask) ≠ 0. Committed and uncommitted entries are both candidates.
  - Only the youngest candidate, nearest tail, is used.
  - If its mask covers the load mask: hit=1, and data is the selected lanes shifted down, then sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
  - If it covers the load mask only partially: stall=1, hit=0.
  - If there is no candidate: hit=0, stall=0, and the load reads the cache.

## Timing
- **Reset values:** all entries invalid, head=tail=0.
  - `out_full`=0, `out_empty`=1, `out_count`=0.
  - `out_drain_valid`=0, `out_drain_addr/data/funct3`=0.
  - Forwarding outputs are 0 while `in_load_valid`=0.
- **Reset mid-drain:** discards all entries, committed ones included. The reset values apply on the next cycle.
- **Allocate:** visible to count, full/empty and forwarding in the cycle after allocation. A same-cycle store→load is not forwarded.
- **Commit:** `out_drain_valid` rises in the cycle after a commit of the head.
- **Drain handshake:** payload and valid are held stable until ready; a new entry can be popped every cycle.
- **Forwarding latency:** zero cycles from load inputs to `out_fwd_*`.

## Test plan
1. Reset; allocate SW 0x100 0xDEADBEEF rob 3 → next cycle count=1, empty=0, drain_valid=0. Then LW 0x100 → hit=1, data=0xDEADBEEF.
2. Commit rob 3 → next cycle drain_valid=1, addr 0x100, funct3 010. Hold ready=0 for 3 cycles → payload stable. Set ready=1 → next cycle empty=1, count=0.
3. SB 0x203 data 0x80:
   - LB 0x203 → 0xFFFFFF80.
   - LBU 0x203 → 0x00000080.
   - LW 0x200 → stall=1.
   - LB 0x202 → hit=0, stall=0.
4. SW 0x300 0x11111111, then SB 0x300 0x22:
   - LB 0x300 → 0x00000022.
   - LH 0x300 → stall=1, because the youngest candidate is partial.
5. DEPTH=4:
   - Allocate 4 stores → full=1; a 5th allocate is ignored.
   - Commit the first two, then flush → count=2, and the drain emits exactly those two in order.
   - A subsequent allocate is accepted.
6. Commit and flush in the same cycle for the head entry → the entry survives and drains. Reset asserted while drain_valid=1 → empty=1 and drain_valid=0 on the next cycle.
